spram_bank_ctl: RTL and testbench

//  Parametrised SPRAM array controller: tiles SP256K primitives (16b x 16K) into NCOL lanes x NROW rows

---
 rtl/spram_bank_ctl.sv | 171 +++++++++++++++++
 tb/tb_spram_bank_ctl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_bank_ctl.sv
// SPRAM array controller: NROW rows x DW/16 lanes of 16b x 16K single-port tiles behind a
// req/rdy slave port, with a two-stage registered read path and per-row idle standby.
module spram_bank_ctl #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NROW     = 2,
    parameter int unsigned IDLE_CYC = 64,
    parameter int unsigned WAKE_CYC = 2,
    localparam int unsigned AW      = 14 + $clog2(NROW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            we,
    input  logic [AW-1:0]   ai,
    input  logic [DW-1:0]   vi,
    input  logic [DW/8-1:0] bmsk,
    input  logic            pwr_save,
    output logic            rdy,
    output logic [DW-1:0]   vo,
    output logic            vo_vld,
    output logic [NROW-1:0] stby
);
    localparam int unsigned NCOL = DW / 16;
    localparam int unsigned RW   = (NROW > 1) ? $clog2(NROW) : 1;
    localparam int unsigned IW   = (IDLE_CYC > 0) ? $clog2(IDLE_CYC + 1) : 1;
    localparam int unsigned WW   = $clog2(WAKE_CYC + 1);

    typedef enum logic [1:0] {StAct, StStby, StWake} row_st_e;

    row_st_e                  st_q   [NROW];
    row_st_e                  st_d   [NROW];
    logic [IW-1:0]            idle_q [NROW];
    logic [IW-1:0]            idle_d [NROW];
    logic [WW-1:0]            wake_q [NROW];
    logic [WW-1:0]            wake_d [NROW];
    logic [NROW-1:0]          hit;
    logic [RW-1:0]            req_row;
    logic                     accept;
    logic [NROW-1:0][DW-1:0]  do_row;

    logic          rd_vld_q, rd_vld_d;
    logic [RW-1:0] rsel_q, rsel_d;
    logic          vo_vld_q, vo_vld_d;
    logic [DW-1:0] vo_q, vo_d;

    if (NROW > 1) begin : g_rowsel
        assign req_row = ai[AW-1:14];
    end else begin : g_rowsel_one
        assign req_row = '0;
    end

    assign rdy    = (st_q[req_row] == StAct);
    assign accept = req && rdy;

    always_comb begin
        hit = '0;
        for (int r = 0; r < NROW; r++) begin
            hit[r] = accept && (req_row == RW'(r));
        end
    end

    // Idle count only advances while ACT; WAKE and STBY hold it at zero.
    always_comb begin
        for (int r = 0; r < NROW; r++) begin
            st_d[r]   = st_q[r];
            idle_d[r] = '0;
            wake_d[r] = '0;
            unique case (st_q[r])
                StAct: begin
                    if (pwr_save && !hit[r] && (IDLE_CYC != 0)) begin
                        idle_d[r] = idle_q[r] + IW'(1);
                        if (idle_d[r] == IW'(IDLE_CYC)) begin
                            st_d[r] = StStby;
                        end
                    end
                end
                StStby: begin
                    if ((req && (req_row == RW'(r))) || !pwr_save) begin
                        st_d[r] = StWake;
                    end
                end
                StWake: begin
                    wake_d[r] = wake_q[r] + WW'(1);
                    if (wake_q[r] == WW'(WAKE_CYC - 1)) begin
                        st_d[r]   = StAct;
                        wake_d[r] = '0;
                    end
                end
                default: st_d[r] = StAct;
            endcase
        end
    end

    always_comb begin
        stby = '0;
        for (int r = 0; r < NROW; r++) begin
            stby[r] = (st_q[r] == StStby);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NROW; r++) begin
                st_q[r]   <= StAct;
                idle_q[r] <= '0;
                wake_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NROW; r++) begin
                st_q[r]   <= st_d[r];
                idle_q[r] <= idle_d[r];
                wake_q[r] <= wake_d[r];
            end
        end
    end

    // Tile array: each lane behaves as one 16b x 16K primitive with a nibble write mask.
    for (genvar r = 0; r < NROW; r++) begin : g_row
        for (genvar c = 0; c < NCOL; c++) begin : g_col
            logic [15:0] mem [16384];
            logic [15:0] dout_q;
            logic        cs;
            logic [3:0]  maskwe;

            assign cs     = hit[r];
            assign maskwe = {{2{bmsk[2*c+1]}}, {2{bmsk[2*c]}}};

            always_ff @(posedge clk) begin
                if (cs) begin
                    if (we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (maskwe[k]) begin
                                mem[ai[13:0]][4*k +: 4] <= vi[16*c + 4*k +: 4];
                            end
                        end
                    end else begin
                        dout_q <= mem[ai[13:0]];
                    end
                end
            end

            assign do_row[r][16*c +: 16] = dout_q;
        end
    end

    // Row select is registered alongside the primitive read so the mux matches its DO cycle.
    always_comb begin
        rd_vld_d = accept && !we;
        rsel_d   = accept ? req_row : rsel_q;
        vo_vld_d = rd_vld_q;
        vo_d     = rd_vld_q ? do_row[rsel_q] : vo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rsel_q   <= '0;
            vo_vld_q <= 1'b0;
            vo_q     <= '0;
        end else begin
            rd_vld_q <= rd_vld_d;
            rsel_q   <= rsel_d;
            vo_vld_q <= vo_vld_d;
            vo_q     <= vo_d;
        end
    end

    assign vo     = vo_q;
    assign vo_vld = vo_vld_q;

endmodule

// File: tb/tb_spram_bank_ctl.sv
// Bench for spram_bank_ctl: directed vector table, power-state sequences and random traffic,
// all checked every cycle against a cycle-stamped behavioural model.
module tb_spram_bank_ctl;
    localparam int DW   = 32;
    localparam int NROW = 2;
    localparam int IDLE = 64;
    localparam int WAKE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [14:0] ai = '0;
    logic [31:0] vi = '0;
    logic [3:0]  bmsk = '0;
    logic        pwr_save = 1'b0;
    logic        rdy;
    logic [31:0] vo;
    logic        vo_vld;
    logic [1:0]  stby;

    spram_bank_ctl #(
        .DW       (DW),
        .NROW     (NROW),
        .IDLE_CYC (IDLE),
        .WAKE_CYC (WAKE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .ai       (ai),
        .vi       (vi),
        .bmsk     (bmsk),
        .pwr_save (pwr_save),
        .rdy      (rdy),
        .vo       (vo),
        .vo_vld   (vo_vld),
        .stby     (stby)
    );

    always #5 clk = ~clk;

    // Model: a row is ready from cycle m_ready on unless asleep; m_quiet is the first idle cycle.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    typedef struct {
        logic        w;
        logic [14:0] a;
        logic [31:0] d;
        logic [3:0]  m;
        logic [31:0] exp;
    } vec_t;

    int          t;
    bit          m_asleep [NROW];
    int          m_ready  [NROW];
    int          m_quiet  [NROW];
    logic [31:0] m_mem    [int];
    rd_t         rq[$];
    logic [31:0] m_vo;
    int          n_tests = 0;
    int          n_fail = 0;
    bit          last_acc;
    logic        s_vld;
    logic        s_rdy;
    logic [31:0] s_vo;
    vec_t        vt [11];
    logic [14:0] pool [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    function automatic bit m_rdy(input int r);
        return !m_asleep[r] && (t >= m_ready[r]);
    endfunction

    function automatic void m_write(input int a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = m_mem.exists(a) ? m_mem[a] : 32'h0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        m_mem[a] = w;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < NROW; k++) begin
            m_asleep[k] = 1'b0;
            m_ready[k]  = 0;
            m_quiet[k]  = 0;
        end
        rq.delete();
        m_vo = 32'h0;
        t    = 0;
    endfunction

    // Entered at a negedge with inputs driven; checks this cycle, then advances one clock.
    task automatic step();
        bit  exp_vld;
        bit  acc;
        int  r;
        rd_t e;
        #1;
        exp_vld = 1'b0;
        if (rq.size() > 0 && rq[0].due == t) begin
            m_vo = rq[0].data;
            void'(rq.pop_front());
            exp_vld = 1'b1;
        end
        s_vld = vo_vld;
        s_vo  = vo;
        s_rdy = rdy;
        r = int'(ai[14]);
        if (req) chk("rdy", 32'(rdy), 32'(m_rdy(r)));
        chk("stby", 32'(stby), 32'({m_asleep[1], m_asleep[0]}));
        chk("vo_vld", 32'(vo_vld), 32'(exp_vld));
        chk("vo", vo, m_vo);
        acc = req && m_rdy(r);
        for (int k = 0; k < NROW; k++) begin
            if (m_asleep[k]) begin
                if ((req && r == k) || !pwr_save) begin
                    m_asleep[k] = 1'b0;
                    m_ready[k]  = t + 1 + WAKE;
                    m_quiet[k]  = m_ready[k];
                end
            end else if (t >= m_ready[k]) begin
                if ((acc && r == k) || !pwr_save) m_quiet[k] = t + 1;
                else if (t + 1 - m_quiet[k] >= IDLE) m_asleep[k] = 1'b1;
            end
        end
        if (acc) begin
            if (we) begin
                m_write(int'(ai), vi, bmsk);
            end else begin
                e.due  = t + 2;
                e.data = m_mem[int'(ai)];
                rq.push_back(e);
            end
        end
        last_acc = acc;
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic do_access(input logic w, input logic [14:0] a, input logic [31:0] d,
                             input logic [3:0] m, output int waits);
        req   = 1'b1;
        we    = w;
        ai    = a;
        vi    = d;
        bmsk  = m;
        waits = 0;
        step();
        while (!last_acc && waits < 20) begin
            waits++;
            step();
        end
        chk("accept", 32'(last_acc), 32'd1);
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_vo", vo, 32'h0);
        chk("rst_stby", 32'(stby), 32'h0);
        for (int i = 0; i < n; i++) begin
            chk("rst_vld", 32'(vo_vld), 32'h0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        int waits;
        int pulses;
        int idle_left;
        bit busy;

        vt[0]  = '{1'b1, 15'h0000, 32'hDEADBEEF, 4'hF, 32'h0};
        vt[1]  = '{1'b0, 15'h0000, 32'h0,        4'h0, 32'hDEADBEEF};
        vt[2]  = '{1'b1, 15'h0005, 32'h55667788, 4'hF, 32'h0};
        vt[3]  = '{1'b1, 15'h4005, 32'h11223344, 4'hF, 32'h0};
        vt[4]  = '{1'b1, 15'h4005, 32'hAABBCCDD, 4'h2, 32'h0};
        vt[5]  = '{1'b0, 15'h4005, 32'h0,        4'h0, 32'h1122CC44};
        vt[6]  = '{1'b0, 15'h0005, 32'h0,        4'h0, 32'h55667788};
        vt[7]  = '{1'b1, 15'h4005, 32'hFFFFFFFF, 4'h0, 32'h0};
        vt[8]  = '{1'b0, 15'h4005, 32'h0,        4'h0, 32'h1122CC44};
        vt[9]  = '{1'b1, 15'h0005, 32'hA1B2C3D4, 4'h9, 32'h0};
        vt[10] = '{1'b0, 15'h0005, 32'h0,        4'h0, 32'hA16677D4};
        for (int i = 0; i < 16; i++) pool[i] = {(i >= 8), 14'(i * 37 + 3)};

        m_reset();
        do_reset(2);

        // Directed vectors: write/read, byte masks, bmsk=0 write, row separation.
        foreach (vt[i]) begin
            do_access(vt[i].w, vt[i].a, vt[i].d, vt[i].m, waits);
            if (!vt[i].w) begin
                step();
                step();
                chk("tbl_vld", 32'(s_vld), 32'd1);
                chk("tbl_vo", s_vo, vt[i].exp);
            end
        end

        // Back-to-back reads alternating rows.
        for (int i = 0; i < 8; i++) begin
            do_access(1'b1, (i % 2 != 0) ? 15'h4010 + 15'(i / 2) : 15'h0010 + 15'(i / 2),
                      32'hC0DE0000 + 32'(i * 32'h01010101), 4'hF, waits);
        end
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            req = (i < 8);
            we  = 1'b0;
            ai  = (i % 2 != 0) ? 15'h4010 + 15'(i / 2) : 15'h0010 + 15'(i / 2);
            step();
            if (i < 8) chk("stream_rdy", 32'(s_rdy), 32'd1);
            if (s_vld) pulses++;
        end
        req = 1'b0;
        chk("stream_pulses", 32'(pulses), 32'd8);

        // Idle power-down after exactly IDLE cycles, then wake on request.
        pwr_save = 1'b0;
        step();
        pwr_save = 1'b1;
        repeat (IDLE - 1) step();
        chk("stby_before", 32'(stby), 32'h0);
        step();
        chk("stby_sleep", 32'(stby), 32'h3);
        do_access(1'b0, 15'h0000, 32'h0, 4'h0, waits);
        chk("wake_wait", 32'(waits), 32'(WAKE + 1));
        chk("stby_row0_up", 32'(stby), 32'h2);
        step();
        step();
        chk("wake_vo", s_vo, 32'hDEADBEEF);

        // Dropping pwr_save wakes row1 and keeps everything awake.
        pwr_save = 1'b0;
        step();
        chk("stby_drop", 32'(stby), 32'h0);
        do_access(1'b0, 15'h4010, 32'h0, 4'h0, waits);
        chk("wake_wait_ps0", 32'(waits), 32'(WAKE));
        repeat (100) step();
        chk("no_powerdown", 32'(stby), 32'h0);

        // Reset one cycle after a read is accepted.
        do_access(1'b0, 15'h0011, 32'h0, 4'h0, waits);
        do_reset(3);
        repeat (4) step();
        do_access(1'b0, 15'h0000, 32'h0, 4'h0, waits);
        chk("post_rst_row0", 32'(waits), 32'h0);
        do_access(1'b1, 15'h4000, 32'h0BADF00D, 4'hF, waits);
        chk("post_rst_row1", 32'(waits), 32'h0);

        // Random traffic over a small address pool, with idle bursts and pwr_save toggles.
        foreach (pool[i]) do_access(1'b1, pool[i], $urandom(), 4'hF, waits);
        pwr_save  = 1'b1;
        busy      = 1'b0;
        idle_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy) begin
                req = 1'b0;
                if (idle_left > 0) begin
                    idle_left--;
                end else if ($urandom_range(0, 63) == 0) begin
                    idle_left = $urandom_range(30, 90);
                end else if ($urandom_range(0, 3) != 0) begin
                    busy = 1'b1;
                    req  = 1'b1;
                    we   = 1'($urandom_range(0, 1));
                    ai   = pool[$urandom_range(0, 15)];
                    vi   = $urandom();
                    bmsk = 4'($urandom_range(0, 15));
                end
            end
            if ($urandom_range(0, 299) == 0) pwr_save = ~pwr_save;
            step();
            if (last_acc) begin
                busy = 1'b0;
                req  = 1'b0;
            end
        end
        req = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
